// File: rtl/exec_ctrl_if.sv
// Bus between exec_ctrl and its surroundings: program ROM port, ALU port and
// the architectural state made visible to the outside.
interface exec_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNTR_WIDTH = 8
);
  logic                             run_en;
  logic [CNTR_WIDTH-1:0]            prog_addr;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] prog_data;
  logic [DATA_WIDTH-1:0]            alu_in1;
  logic [DATA_WIDTH-1:0]            alu_in2;
  logic [ADDR_WIDTH-1:0]            alu_op;
  logic [DATA_WIDTH-1:0]            alu_result;
  logic                             alu_zero_f;
  logic                             alu_ls_z_f;
  logic                             alu_gr_z_f;
  logic [DATA_WIDTH-1:0]            acc;
  logic [2:0]                       flags;
  logic [CNTR_WIDTH-1:0]            pc;
  logic                             halted;
  logic                             illegal;

  modport master (
    input  run_en, prog_data, alu_result, alu_zero_f, alu_ls_z_f, alu_gr_z_f,
    output prog_addr, alu_in1, alu_in2, alu_op, acc, flags, pc, halted, illegal
  );

  modport slave (
    output run_en, prog_data, alu_result, alu_zero_f, alu_ls_z_f, alu_gr_z_f,
    input  prog_addr, alu_in1, alu_in2, alu_op, acc, flags, pc, halted, illegal
  );
endinterface

// File: rtl/exec_ctrl.sv
// Fetch/decode/execute sequencer that drives a combinational ALU and owns
// pc, acc, flags and the register file.
module exec_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int CNTR_WIDTH  = 8,
  parameter int REG_BIT_CNT = 3
) (
  input logic         clk,
  input logic         rst,
  exec_ctrl_if.master bus
);
  localparam int NUM_REGS = 2 ** REG_BIT_CNT;

  localparam logic [ADDR_WIDTH-1:0] OP_NOP  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OP_XOR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OP_OR   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OP_AND  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OP_SUBR = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OP_ADDR = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] OP_LDR  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] OP_SUBI = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] OP_ADDI = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] OP_LDI  = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] OP_SR   = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] OP_SL   = ADDR_WIDTH'(11);
  localparam logic [ADDR_WIDTH-1:0] OP_RR   = ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] OP_RL   = ADDR_WIDTH'(13);
  localparam logic [ADDR_WIDTH-1:0] OP_DEC  = ADDR_WIDTH'(14);
  localparam logic [ADDR_WIDTH-1:0] OP_INC  = ADDR_WIDTH'(15);
  localparam logic [ADDR_WIDTH-1:0] OP_NOT  = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] OP_JMP  = ADDR_WIDTH'(17);
  localparam logic [ADDR_WIDTH-1:0] OP_JZ   = ADDR_WIDTH'(18);
  localparam logic [ADDR_WIDTH-1:0] OP_JLZ  = ADDR_WIDTH'(19);
  localparam logic [ADDR_WIDTH-1:0] OP_JGZ  = ADDR_WIDTH'(20);
  localparam logic [ADDR_WIDTH-1:0] OP_STR  = ADDR_WIDTH'(21);
  localparam logic [ADDR_WIDTH-1:0] OP_HLT  = ADDR_WIDTH'(22);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_e;

  typedef enum logic [2:0] {
    CLS_ALU_REG, CLS_ALU_IMM, CLS_ALU, CLS_JUMP, CLS_STORE, CLS_HALT, CLS_ILLEGAL
  } opclass_e;

  function automatic opclass_e classify(input logic [ADDR_WIDTH-1:0] op);
    opclass_e cls;
    case (op)
      OP_XOR, OP_OR, OP_AND, OP_SUBR, OP_ADDR, OP_LDR: cls = CLS_ALU_REG;
      OP_SUBI, OP_ADDI, OP_LDI:                        cls = CLS_ALU_IMM;
      OP_NOP, OP_SR, OP_SL, OP_RR, OP_RL,
      OP_DEC, OP_INC, OP_NOT:                          cls = CLS_ALU;
      OP_JMP, OP_JZ, OP_JLZ, OP_JGZ:                   cls = CLS_JUMP;
      OP_STR:                                          cls = CLS_STORE;
      OP_HLT:                                          cls = CLS_HALT;
      default:                                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_e                           state_q;
  logic [CNTR_WIDTH-1:0]            pc_q;
  logic [CNTR_WIDTH-1:0]            pc_d;
  logic [DATA_WIDTH-1:0]            acc_q;
  logic [2:0]                       flags_q;
  logic [DATA_WIDTH-1:0]            regs_q [NUM_REGS];
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ir_q;
  logic [ADDR_WIDTH-1:0]            aluOp_q;
  logic [DATA_WIDTH-1:0]            aluIn2_q;
  logic                             halted_q;
  logic                             illegal_q;

  logic [ADDR_WIDTH-1:0] irOp;
  logic [DATA_WIDTH-1:0] irArg;
  opclass_e              irClass;
  logic [ADDR_WIDTH-1:0] decOp;
  logic [DATA_WIDTH-1:0] decArg;
  opclass_e              decClass;
  logic                  jumpTaken;

  assign irOp     = ir_q[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign irArg    = ir_q[DATA_WIDTH-1:0];
  assign irClass  = classify(irOp);
  assign decOp    = bus.prog_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign decArg   = bus.prog_data[DATA_WIDTH-1:0];
  assign decClass = classify(decOp);

  // Conditional jumps look only at the latched flags, never the live ALU flags.
  always_comb begin
    jumpTaken = 1'b0;
    case (irOp)
      OP_JMP:  jumpTaken = 1'b1;
      OP_JZ:   jumpTaken = flags_q[0];
      OP_JLZ:  jumpTaken = flags_q[1];
      OP_JGZ:  jumpTaken = flags_q[2];
      default: jumpTaken = 1'b0;
    endcase
    pc_d = pc_q + CNTR_WIDTH'(1);
    if (irClass == CLS_HALT) begin
      pc_d = pc_q;
    end else if (jumpTaken) begin
      pc_d = irArg[CNTR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      acc_q     <= '0;
      flags_q   <= '0;
      ir_q      <= '0;
      aluOp_q   <= OP_NOP;
      aluIn2_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.run_en) begin
            state_q <= DECODE;
          end
        end
        // ALU operands are registered here so they are stable for all of EXECUTE.
        DECODE: begin
          ir_q      <= bus.prog_data;
          state_q   <= EXECUTE;
          illegal_q <= (decClass == CLS_ILLEGAL);
          case (decClass)
            CLS_ALU_REG: begin
              aluOp_q  <= decOp;
              aluIn2_q <= regs_q[decArg[REG_BIT_CNT-1:0]];
            end
            CLS_ALU_IMM: begin
              aluOp_q  <= decOp;
              aluIn2_q <= decArg;
            end
            CLS_ALU: begin
              aluOp_q  <= decOp;
              aluIn2_q <= '0;
            end
            default: begin
              aluOp_q  <= OP_NOP;
              aluIn2_q <= '0;
            end
          endcase
        end
        EXECUTE: begin
          aluOp_q   <= OP_NOP;
          aluIn2_q  <= '0;
          illegal_q <= 1'b0;
          pc_q      <= pc_d;
          if (irClass == CLS_ALU_REG || irClass == CLS_ALU_IMM || irClass == CLS_ALU) begin
            acc_q   <= bus.alu_result;
            flags_q <= {bus.alu_gr_z_f, bus.alu_ls_z_f, bus.alu_zero_f};
          end
          if (irClass == CLS_STORE) begin
            regs_q[irArg[REG_BIT_CNT-1:0]] <= acc_q;
          end
          if (irClass == CLS_HALT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.acc       = acc_q;
  assign bus.alu_in1   = acc_q;
  assign bus.alu_in2   = aluIn2_q;
  assign bus.alu_op    = aluOp_q;
  assign bus.flags     = flags_q;
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a ROM and an ALU surround the DUT while an instruction-level
// reference model predicts the outputs of every cycle.
module tb_exec_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int RB = 3;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_XOR = 5'd1,  OP_OR  = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_SUBR = 5'd4, OP_ADDR = 5'd5, OP_LDR = 5'd6,  OP_SUBI = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8, OP_LDI = 5'd9,  OP_SR  = 5'd10, OP_SL = 5'd11;
  localparam logic [4:0] OP_RR = 5'd12,  OP_RL = 5'd13,  OP_DEC = 5'd14, OP_INC = 5'd15;
  localparam logic [4:0] OP_NOT = 5'd16, OP_JMP = 5'd17, OP_JZ  = 5'd18, OP_JLZ = 5'd19;
  localparam logic [4:0] OP_JGZ = 5'd20, OP_STR = 5'd21, OP_HLT = 5'd22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNTR_WIDTH(CW)) bus ();

  exec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNTR_WIDTH(CW), .REG_BIT_CNT(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment: synchronous program ROM and combinational ALU.
  logic [12:0] rom [256];
  logic [12:0] romQ;
  always @(posedge clk) romQ <= rom[bus.prog_addr];
  assign bus.prog_data = romQ;

  function automatic logic [7:0] aluRef(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_XOR:          return a ^ b;
      OP_OR:           return a | b;
      OP_AND:          return a & b;
      OP_SUBR, OP_SUBI: return a - b;
      OP_ADDR, OP_ADDI: return a + b;
      OP_LDR, OP_LDI:  return b;
      OP_SR:           return a >> 1;
      OP_SL:           return a << 1;
      OP_RR:           return {a[0], a[7:1]};
      OP_RL:           return {a[6:0], a[7]};
      OP_DEC:          return a - 8'd1;
      OP_INC:          return a + 8'd1;
      OP_NOT:          return ~a;
      default:         return a;
    endcase
  endfunction

  function automatic logic [2:0] flagsOf(input logic [7:0] r);
    return {(r != 8'd0) && !r[7], r[7], r == 8'd0};
  endfunction

  logic [7:0] aluR;
  always_comb aluR = aluRef(bus.alu_op, bus.alu_in1, bus.alu_in2);
  assign bus.alu_result = aluR;
  assign bus.alu_gr_z_f = flagsOf(aluR)[2];
  assign bus.alu_ls_z_f = flagsOf(aluR)[1];
  assign bus.alu_zero_f = flagsOf(aluR)[0];

  // 0 register ALU, 1 immediate ALU, 2 other ALU, 3 jump, 4 store, 5 halt, 6 illegal
  function automatic int classOf(input logic [4:0] op);
    if (op inside {OP_XOR, OP_OR, OP_AND, OP_SUBR, OP_ADDR, OP_LDR}) return 0;
    if (op inside {OP_SUBI, OP_ADDI, OP_LDI}) return 1;
    if (op inside {OP_NOP, OP_SR, OP_SL, OP_RR, OP_RL, OP_DEC, OP_INC, OP_NOT}) return 2;
    if (op inside {OP_JMP, OP_JZ, OP_JLZ, OP_JGZ}) return 3;
    if (op == OP_STR) return 4;
    if (op == OP_HLT) return 5;
    return 6;
  endfunction

  function automatic logic [12:0] mk(input logic [4:0] op, input logic [7:0] arg);
    return {op, arg};
  endfunction

  // Architectural reference model
  logic [7:0] mPc, mAcc;
  logic [2:0] mFlags;
  logic [7:0] mRegs [8];
  bit         mHalted;

  // Expected outputs for the current cycle
  logic [7:0] expPc, expAcc, expIn2;
  logic [2:0] expFlags;
  logic [4:0] expOp;
  bit         expHalted, expIllegal, expExec;
  bit         checkEn = 1'b0;

  int total = 0;
  int bad = 0;
  int accSeq [6] = '{3, 3, 10, 7, 10, 0};
  int pcSeq [4]  = '{1, 2, 3, 32};

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("prog_addr", bus.prog_addr, expPc);
    checkOne("pc", bus.pc, expPc);
    checkOne("acc", bus.acc, expAcc);
    checkOne("alu_in1", bus.alu_in1, expAcc);
    checkOne("flags", bus.flags, expFlags);
    checkOne("halted", bus.halted, expHalted);
    checkOne("illegal", bus.illegal, expIllegal);
    checkOne("alu_op", bus.alu_op, expOp);
    if (expExec) checkOne("alu_in2", bus.alu_in2, expIn2);
  endtask

  always @(negedge clk) if (checkEn) checkOutput();

  task automatic modelReset();
    mPc = 8'd0; mAcc = 8'd0; mFlags = 3'b000; mHalted = 1'b0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'd0;
  endtask

  task automatic setIdleExp();
    expPc = mPc; expAcc = mAcc; expFlags = mFlags; expHalted = mHalted;
    expIllegal = 1'b0; expExec = 1'b0; expOp = OP_NOP; expIn2 = 8'd0;
  endtask

  task automatic setExecExp(input logic [12:0] instr);
    int cls;
    cls = classOf(instr[12:8]);
    expExec    = 1'b1;
    expIllegal = (cls == 6);
    expOp      = (cls <= 2) ? instr[12:8] : OP_NOP;
    expIn2     = (cls == 0) ? mRegs[instr[2:0]] : (cls == 1) ? instr[7:0] : 8'd0;
  endtask

  task automatic modelExec(input logic [12:0] instr);
    logic [4:0] op;
    logic [7:0] arg, r;
    int cls;
    bit taken;
    op = instr[12:8]; arg = instr[7:0]; cls = classOf(op);
    if (cls <= 2) begin
      r = aluRef(op, mAcc, (cls == 0) ? mRegs[arg[2:0]] : (cls == 1) ? arg : 8'd0);
      mAcc = r; mFlags = flagsOf(r); mPc = mPc + 8'd1;
    end else if (cls == 3) begin
      taken = (op == OP_JMP) || (op == OP_JZ && mFlags[0]) ||
              (op == OP_JLZ && mFlags[1]) || (op == OP_JGZ && mFlags[2]);
      mPc = taken ? arg : mPc + 8'd1;
    end else if (cls == 4) begin
      mRegs[arg[2:0]] = mAcc; mPc = mPc + 8'd1;
    end else if (cls == 5) begin
      mHalted = 1'b1;
    end else begin
      mPc = mPc + 8'd1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.run_en = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    modelReset(); setIdleExp();
    @(posedge clk); #1;
    rst = 1'b0; bus.run_en = 1'b0;
  endtask

  // Runs one instruction starting from FETCH; optionally resets during its EXECUTE.
  task automatic applyStimulus(input int idle, input bit abortInExec);
    logic [12:0] instr;
    bus.run_en = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.run_en = 1'b1;
    @(posedge clk); #1;
    bus.run_en = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    instr = rom[mPc];
    setExecExp(instr);
    bus.run_en = 1'($urandom_range(0, 1));
    if (abortInExec) rst = 1'b1;
    @(posedge clk); #1;
    if (abortInExec) begin
      rst = 1'b0; modelReset();
    end else begin
      modelExec(instr);
    end
    bus.run_en = 1'b0;
    setIdleExp();
  endtask

  task automatic haltCycles(input int n);
    repeat (n) begin
      bus.run_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.run_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, 8'd0);
    bus.run_en = 1'b0;
    modelReset(); setIdleExp();
    doReset();
    checkEn = 1'b1;

    checkOne("reset_prog_addr", bus.prog_addr, 0);
    checkOne("reset_acc", bus.acc, 0);
    checkOne("reset_flags", bus.flags, 0);
    rom[0] = mk(OP_LDI, 8'd5);
    applyStimulus(0, 1'b0);
    checkOne("ldi5_acc", bus.acc, 5);
    checkOne("ldi5_flags", bus.flags, 3'b100);
    checkOne("ldi5_pc", bus.pc, 1);

    doReset();
    rom[0] = mk(OP_LDI, 8'd3);  rom[1] = mk(OP_STR, 8'd2);  rom[2] = mk(OP_LDI, 8'd10);
    rom[3] = mk(OP_SUBR, 8'd2); rom[4] = mk(OP_ADDR, 8'd2); rom[5] = mk(OP_SUBI, 8'd10);
    rom[6] = mk(OP_LDR, 8'd2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(0, 2), 1'b0);
      checkOne($sformatf("seq_acc%0d", i), bus.acc, accSeq[i]);
    end
    checkOne("seq_flags", bus.flags, 3'b001);
    applyStimulus(0, 1'b0);
    checkOne("ldr_reg2", bus.acc, 3);

    doReset();
    rom[0] = mk(OP_LDI, 8'hFF); rom[1] = mk(OP_JZ, 8'h10);
    rom[2] = mk(OP_JGZ, 8'h10); rom[3] = mk(OP_JLZ, 8'h20);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0);
      checkOne($sformatf("jmp_pc%0d", i), bus.pc, pcSeq[i]);
    end
    checkOne("jmp_flags", bus.flags, 3'b010);

    doReset();
    rom[0] = mk(OP_JMP, 8'hFF); rom[255] = mk(OP_NOP, 8'd0);
    applyStimulus(0, 1'b0);
    checkOne("jmpff_pc", bus.pc, 8'hFF);
    applyStimulus(1, 1'b0);
    checkOne("wrap_pc", bus.pc, 0);

    doReset();
    rom[0] = mk(OP_INC, 8'd0); rom[1] = mk(OP_INC, 8'd0); rom[2] = mk(OP_INC, 8'd0);
    rom[3] = mk(OP_NOP, 8'd0); rom[4] = mk(OP_HLT, 8'd0);
    repeat (5) begin bus.run_en = 1'b0; @(posedge clk); #1; end
    checkOne("stall_prog_addr", bus.prog_addr, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0);
    checkOne("hlt_halted", bus.halted, 1);
    checkOne("hlt_acc", bus.acc, 3);
    haltCycles(10);
    checkOne("hlt_pc_held", bus.pc, 4);
    doReset();
    checkOne("hlt_reset_pc", bus.pc, 0);
    checkOne("hlt_reset_halted", bus.halted, 0);

    doReset();
    rom[0] = mk(OP_LDI, 8'h42); rom[1] = mk(5'd25, 8'h11);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOne("ill_acc", bus.acc, 8'h42);
    checkOne("ill_flags", bus.flags, 3'b100);
    checkOne("ill_pc", bus.pc, 2);

    doReset();
    rom[0] = mk(OP_ADDI, 8'd7);
    applyStimulus(0, 1'b1);
    checkOne("abort_acc", bus.acc, 0);
    checkOne("abort_pc", bus.pc, 0);
    applyStimulus(0, 1'b0);
    checkOne("after_abort_acc", bus.acc, 7);

    doReset();
    for (int i = 0; i < 256; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == OP_HLT && $urandom_range(0, 9) != 0) op = OP_INC;
      rom[i] = mk(op, 8'($urandom_range(0, 255)));
    end
    for (int n = 0; n < 400; n++) begin
      if (mHalted) begin
        haltCycles($urandom_range(1, 3));
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 2), $urandom_range(0, 49) == 0);
      end
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
